// File: rtl/tail_seq_pkg.sv
// Shared types and limits for the sequential turn-signal controller.
package tail_seq_pkg;

  localparam int unsigned TAIL_LAMPS_MAX = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEFT    = 3'd1,
    ST_RIGHT   = 3'd2,
    ST_HAZ_ON  = 3'd3,
    ST_HAZ_OFF = 3'd4
  } tail_state_t;

endpackage

// File: rtl/tail_seq_prescaler.sv
// Step-period divider: tick pulses every TICK_DIV clocks, restartable via clr.
module tail_seq_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $fatal(1, "tail_seq_prescaler: TICK_DIV must be >= 1");
  end

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/tail_seq.sv
// Sequential turn-signal controller; hazard flashing is enabled by TAIL_SEQ_HAZARD_EN.
module tail_seq
  import tail_seq_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic             busy
);

  if (LAMPS < 1 || LAMPS > int'(TAIL_LAMPS_MAX)) begin : g_bad_lamps
    $fatal(1, "tail_seq: LAMPS must be in 1..16");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $fatal(1, "tail_seq: TICK_DIV must be >= 1");
  end

  localparam int unsigned SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

  tail_state_t      state, state_nxt;
  logic [SW-1:0]    step, step_nxt;
  logic [LAMPS-1:0] mask_nxt, lamp_l_nxt, lamp_r_nxt;
  logic             busy_nxt;
  logic             tick;
  logic             clr_c;

  tail_seq_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_c),
    .tick  (tick)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      ST_IDLE: begin
        step_nxt = '0;
        if (left && !right) begin
          state_nxt = ST_LEFT;
          step_nxt  = SW'(1);
        end else if (!left && right) begin
          state_nxt = ST_RIGHT;
          step_nxt  = SW'(1);
        end
      end
      ST_LEFT, ST_RIGHT: begin
        if (step == '0 || step > LAST_STEP) begin
          state_nxt = ST_IDLE;
          step_nxt  = '0;
        end else if (tick) begin
          if (step == LAST_STEP) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
          end else begin
            step_nxt = step + SW'(1);
          end
        end
      end
`ifdef TAIL_SEQ_HAZARD_EN
      ST_HAZ_ON: begin
        step_nxt = '0;
        if (!(left && right)) state_nxt = ST_IDLE;
        else if (tick)        state_nxt = ST_HAZ_OFF;
      end
      ST_HAZ_OFF: begin
        step_nxt = '0;
        if (!(left && right)) state_nxt = ST_IDLE;
        else if (tick)        state_nxt = ST_HAZ_ON;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
        step_nxt  = '0;
      end
    endcase

    // Both requests override any running sequence without waiting for tick
`ifdef TAIL_SEQ_HAZARD_EN
    if (left && right && state != ST_HAZ_ON && state != ST_HAZ_OFF) begin
      state_nxt = ST_HAZ_ON;
      step_nxt  = '0;
    end
`else
    if (left && right) begin
      state_nxt = ST_IDLE;
      step_nxt  = '0;
    end
`endif

    clr_c = (state == ST_IDLE) || (state_nxt != state);
  end

  // Moore decode of the upcoming state, so outputs register alongside it
  always_comb begin
    for (int i = 0; i < LAMPS; i++) begin
      mask_nxt[i] = (step_nxt > SW'(i));
    end
    lamp_l_nxt = '0;
    lamp_r_nxt = '0;
    case (state_nxt)
      ST_LEFT:   lamp_l_nxt = mask_nxt;
      ST_RIGHT:  lamp_r_nxt = mask_nxt;
      ST_HAZ_ON: begin
        lamp_l_nxt = '1;
        lamp_r_nxt = '1;
      end
      default: ;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      step   <= '0;
      lamp_l <= '0;
      lamp_r <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      lamp_l <= lamp_l_nxt;
      lamp_r <= lamp_r_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tail_seq.sv
// Randomized and directed check of tail_seq against a time-based behavioural model.
module tb_tail_seq;

  localparam int LAMPS = 4;
  localparam int TD    = 3;
  localparam int SEQ   = LAMPS * TD;

  logic             clk;
  logic             reset;
  logic             left;
  logic             right;
  logic [LAMPS-1:0] lamp_l;
  logic [LAMPS-1:0] lamp_r;
  logic             busy;

  int tests;
  int fails;

  // Model: mode 0 idle, 1 left, 2 right, 3 hazard; t = cycles since mode entry
  int m_mode;
  int m_t;

`ifdef TAIL_SEQ_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  tail_seq #(.LAMPS(LAMPS), .TICK_DIV(TD)) dut (
    .clk    (clk),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .lamp_l (lamp_l),
    .lamp_r (lamp_r),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic l, input logic r, input logic rst);
    if (rst) begin
      m_mode = 0;
    end else if (HAZ && l && r && m_mode != 3) begin
      m_mode = 3;
      m_t    = 0;
    end else if (m_mode == 3) begin
      if (!(l && r)) m_mode = 0;
      else m_t++;
    end else if (l && r) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (l) begin
        m_mode = 1;
        m_t    = 0;
      end else if (r) begin
        m_mode = 2;
        m_t    = 0;
      end
    end else begin
      m_t++;
      if (m_t == SEQ) m_mode = 0;
    end
  endtask

  task automatic check(input string tag);
    logic [LAMPS-1:0] bar;
    logic [LAMPS-1:0] exp_l;
    logic [LAMPS-1:0] exp_r;
    logic             exp_b;
    int               lit;
    lit = m_t / TD + 1;
    for (int i = 0; i < LAMPS; i++) bar[i] = (i < lit);
    exp_l = '0;
    exp_r = '0;
    if (m_mode == 1) exp_l = bar;
    if (m_mode == 2) exp_r = bar;
    if (m_mode == 3 && ((m_t / TD) % 2 == 0)) begin
      exp_l = '1;
      exp_r = '1;
    end
    exp_b = (m_mode != 0);
    tests++;
    assert (lamp_l === exp_l) else begin
      fails++;
      $error("FAIL %s lamp_l got %b expected %b at %0t", tag, lamp_l, exp_l, $time);
    end
    tests++;
    assert (lamp_r === exp_r) else begin
      fails++;
      $error("FAIL %s lamp_r got %b expected %b at %0t", tag, lamp_r, exp_r, $time);
    end
    tests++;
    assert (busy === exp_b) else begin
      fails++;
      $error("FAIL %s busy got %b expected %b at %0t", tag, busy, exp_b, $time);
    end
  endtask

  task automatic do_step(input logic l, input logic r, input logic rst, input string tag);
    left  = l;
    right = r;
    reset = rst;
    @(posedge clk);
    model_update(l, r, rst);
    #1;
    check(tag);
  endtask

  initial begin
    int code;
    int hold;
    logic l;
    logic r;
    clk    = 1'b0;
    left   = 1'b0;
    right  = 1'b0;
    reset  = 1'b1;
    tests  = 0;
    fails  = 0;
    m_mode = 0;
    m_t    = 0;

    do_step(0, 0, 1, "reset");
    do_step(1, 0, 1, "reset_prio");
    do_step(0, 0, 0, "idle");

    // Single-cycle left pulse runs the full sequence then idles
    do_step(1, 0, 0, "pulse_start");
    repeat (SEQ + 2) do_step(0, 0, 0, "pulse_run");

    // Reset in the middle of a sequence
    do_step(1, 0, 0, "rst_mid_start");
    repeat (TD + 1) do_step(0, 0, 0, "rst_mid_run");
    do_step(1, 0, 1, "rst_mid");
    do_step(0, 0, 0, "rst_mid_after");

    // Held right: two back-to-back sequences with one idle cycle between
    repeat (2 * SEQ + 4) do_step(0, 1, 0, "hold_right");
    do_step(0, 0, 0, "hold_right_drop");
    repeat (SEQ) do_step(0, 0, 0, "drain");

    // Switch request mid-sequence; left completes before right starts
    repeat (TD + 1) do_step(1, 0, 0, "switch_left");
    repeat (SEQ + 4) do_step(0, 1, 0, "switch_right");
    repeat (SEQ + 1) do_step(0, 0, 0, "drain");

    // Both asserted at every prescaler phase
    for (int ph = 0; ph < 2 * TD + 1; ph++) begin
      do_step(1, 0, 0, "both_start");
      repeat (ph) do_step(0, 0, 0, "both_wait");
      do_step(1, 1, 0, "both");
      repeat (2 * TD + 1) do_step(1, 1, 0, "both_hold");
      do_step(0, 0, 0, "both_release");
      repeat (SEQ + 1) do_step(0, 0, 0, "drain");
    end

    // Randomized request segments with occasional reset
    repeat (400) begin
      code = $urandom_range(0, 9);
      l = (code <= 3) || (code == 8);
      r = (code >= 4 && code <= 8);
      hold = $urandom_range(1, 2 * SEQ);
      for (int k = 0; k < hold; k++) begin
        do_step(l, r, ($urandom_range(0, 59) == 0), "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
